addsub_accumulator: RTL and testbench

Sequencing and accumulator stage wrapped around the team's 4-bit `add_subtract` unit. It accepts one command per handshake (load, add, subtract, clear) against an internal 4-bit accumulator and drives the adder/subtractor's `A`, `B` and `Cin` from registered operands. It captures `S`/`Cout` into the accumulator and status flags, then presents the result on a valid/ready output port. It sits between a command source (testbench or controller) and any result consumer.

---
 rtl/addsub_accumulator.sv | 143 ++++++++++++++
 tb/tb_addsub_accumulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accumulator.sv
// Command-driven 4-bit accumulator wrapped around the add_subtract unit:
// accepts LOAD/ADD/SUB/CLEAR on a valid/ready port and returns result + flags.

module add_subtract (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] sum;

    // Cin doubles as the subtract control: it inverts B and supplies the +1.
    assign sum  = {1'b0, A} + {1'b0, B ^ {4{Cin}}} + {4'b0000, Cin};
    assign S    = sum[3:0];
    assign Cout = sum[4];
endmodule

module addsub_accumulator #(
    parameter bit STICKY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [3:0] operand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] result,
    output logic       carry,
    output logic       ovf,
    output logic       zero,
    output logic       sticky_ovf
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t     state;
    logic [1:0] op_q;
    logic [3:0] opnd_q;
    logic [3:0] acc;
    logic [3:0] sum_s;
    logic       sum_cout;
    logic       sub_mode;
    logic [3:0] b_eff;
    logic       arith_ovf;
    logic [3:0] acc_next;
    logic       carry_next;
    logic       ovf_next;

    assign sub_mode = (op_q == OP_SUB);
    assign b_eff    = opnd_q ^ {4{sub_mode}};

    add_subtract u_addsub (
        .A    (acc),
        .B    (opnd_q),
        .Cin  (sub_mode),
        .S    (sum_s),
        .Cout (sum_cout)
    );

    assign arith_ovf = (acc[3] == b_eff[3]) && (sum_s[3] != acc[3]);

    always_comb begin
        acc_next   = acc;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
        case (op_q)
            OP_LOAD:  acc_next = opnd_q;
            OP_ADD,
            OP_SUB: begin
                acc_next   = sum_s;
                carry_next = sum_cout;
                ovf_next   = arith_ovf;
            end
            OP_CLEAR: acc_next = 4'b0000;
            default:  acc_next = acc;
        endcase
    end

    // in_ready/out_valid are registered and always mirror IDLE/RESP respectively.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            opnd_q     <= 4'b0000;
            acc        <= 4'b0000;
            carry      <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
            sticky_ovf <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        opnd_q   <= operand;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    acc   <= acc_next;
                    carry <= carry_next;
                    ovf   <= ovf_next;
                    zero  <= (acc_next == 4'b0000);
                    if (!STICKY_EN || op_q == OP_CLEAR) begin
                        sticky_ovf <= 1'b0;
                    end else begin
                        sticky_ovf <= sticky_ovf | ovf_next;
                    end
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign result = acc;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: directed spec scenarios plus random commands,
// checked against an arithmetic model of the accumulator and its flags.

module tb_addsub_accumulator;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] operand;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       sticky_ovf;

    logic       in_ready0;
    logic       out_valid0;
    logic [3:0] result0;
    logic       carry0;
    logic       ovf0;
    logic       zero0;
    logic       sticky_ovf0;

    int checks   = 0;
    int failures = 0;

    int m_acc    = 0;
    bit m_carry  = 0;
    bit m_ovf    = 0;
    bit m_zero   = 0;
    bit m_sticky = 0;

    addsub_accumulator #(.STICKY_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand    (operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry      (carry),
        .ovf        (ovf),
        .zero       (zero),
        .sticky_ovf (sticky_ovf)
    );

    addsub_accumulator #(.STICKY_EN(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .op         (op),
        .operand    (operand),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .result     (result0),
        .carry      (carry0),
        .ovf        (ovf0),
        .zero       (zero0),
        .sticky_ovf (sticky_ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on integers.
    task automatic model_apply(input logic [1:0] c_op, input logic [3:0] c_opnd);
        int o, sa, so, r;
        o  = int'(c_opnd);
        sa = (m_acc >= 8) ? m_acc - 16 : m_acc;
        so = (o >= 8) ? o - 16 : o;
        case (c_op)
            2'b00: begin m_acc = o; m_carry = 0; m_ovf = 0; end
            2'b01: begin
                r = m_acc + o;
                m_carry = (r > 15);
                m_ovf   = (sa + so > 7) || (sa + so < -8);
                m_acc   = r % 16;
            end
            2'b10: begin
                m_carry = (m_acc >= o);
                m_ovf   = (sa - so > 7) || (sa - so < -8);
                m_acc   = (m_acc - o + 16) % 16;
            end
            default: begin m_acc = 0; m_carry = 0; m_ovf = 0; m_sticky = 0; end
        endcase
        if (c_op != 2'b11) m_sticky = m_sticky | m_ovf;
        m_zero = (m_acc == 0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_result"}, result, 4'(m_acc));
        check({tag, "_carry"}, {3'b0, carry}, {3'b0, m_carry});
        check({tag, "_ovf"}, {3'b0, ovf}, {3'b0, m_ovf});
        check({tag, "_zero"}, {3'b0, zero}, {3'b0, m_zero});
        check({tag, "_sticky"}, {3'b0, sticky_ovf}, {3'b0, m_sticky});
        check({tag, "_result_nosticky"}, result0, 4'(m_acc));
        check({tag, "_sticky_disabled"}, {3'b0, sticky_ovf0}, 4'h0);
    endtask

    // One full command; optionally stalls the output and drives a pending command meanwhile.
    task automatic applyStimulus(input logic [1:0] c_op, input logic [3:0] c_opnd, input int delay,
                                 input bit pend, input logic [1:0] p_op, input logic [3:0] p_opnd);
        int guard;
        in_valid = 1'b1;
        op       = c_op;
        operand  = c_opnd;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check("accept_timeout", {3'b0, in_ready}, 4'h1);
        step();
        in_valid = 1'b0;
        op       = 2'($urandom_range(0, 3));
        operand  = 4'($urandom_range(0, 15));
        model_apply(c_op, c_opnd);
        check("exec_out_valid", {3'b0, out_valid}, 4'h0);
        check("exec_in_ready", {3'b0, in_ready}, 4'h0);
        if (delay == 0) out_ready = 1'b1;
        step();
        check("resp_out_valid", {3'b0, out_valid}, 4'h1);
        check("resp_in_ready", {3'b0, in_ready}, 4'h0);
        checkOutput("resp");
        if (pend) begin
            in_valid = 1'b1;
            op       = p_op;
            operand  = p_opnd;
        end
        for (int i = 0; i < delay; i++) begin
            out_ready = 1'b0;
            step();
            check("stall_out_valid", {3'b0, out_valid}, 4'h1);
            check("stall_in_ready", {3'b0, in_ready}, 4'h0);
            checkOutput("stall");
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("done_out_valid", {3'b0, out_valid}, 4'h0);
        check("done_in_ready", {3'b0, in_ready}, 4'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b01;
        operand   = 4'h5;
        out_ready = 1'b1;
        step();
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("reset_in_ready", {3'b0, in_ready}, 4'h1);
        check("reset_out_valid", {3'b0, out_valid}, 4'h0);
        checkOutput("reset");
        step();
        check("post_reset_out_valid", {3'b0, out_valid}, 4'h0);
        check("post_reset_result", result, 4'h0);

        applyStimulus(2'b00, 4'b0001, 0, 0, 2'b00, 4'h0);
        applyStimulus(2'b01, 4'b0101, 0, 0, 2'b00, 4'h0);
        check("add_result_0110", result, 4'b0110);
        check("add_carry", {3'b0, carry}, 4'h0);

        applyStimulus(2'b00, 4'b0011, 0, 0, 2'b00, 4'h0);
        applyStimulus(2'b10, 4'b0011, 0, 0, 2'b00, 4'h0);
        check("sub_zero_result", result, 4'b0000);
        check("sub_zero_flag", {3'b0, zero}, 4'h1);
        check("sub_zero_carry", {3'b0, carry}, 4'h1);
        applyStimulus(2'b10, 4'b0101, 0, 0, 2'b00, 4'h0);
        check("sub_borrow_result", result, 4'b1011);
        check("sub_borrow_carry", {3'b0, carry}, 4'h0);

        applyStimulus(2'b00, 4'b0111, 0, 0, 2'b00, 4'h0);
        applyStimulus(2'b01, 4'b0001, 0, 0, 2'b00, 4'h0);
        check("ovf_result", result, 4'b1000);
        check("ovf_flag", {3'b0, ovf}, 4'h1);
        check("ovf_sticky", {3'b0, sticky_ovf}, 4'h1);
        applyStimulus(2'b01, 4'b0000, 0, 0, 2'b00, 4'h0);
        check("ovf_clear_flag", {3'b0, ovf}, 4'h0);
        check("ovf_sticky_held", {3'b0, sticky_ovf}, 4'h1);
        applyStimulus(2'b11, 4'h9, 0, 0, 2'b00, 4'h0);
        check("clear_sticky", {3'b0, sticky_ovf}, 4'h0);

        applyStimulus(2'b00, 4'b0110, 5, 1, 2'b01, 4'b0011);
        applyStimulus(2'b01, 4'b0011, 0, 0, 2'b00, 4'h0);

        applyStimulus(2'b00, 4'b0001, 0, 0, 2'b00, 4'h0);
        in_valid = 1'b1;
        op       = 2'b01;
        operand  = 4'b0101;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        m_acc = 0; m_carry = 0; m_ovf = 0; m_zero = 0; m_sticky = 0;
        check("midrst_out_valid", {3'b0, out_valid}, 4'h0);
        check("midrst_in_ready", {3'b0, in_ready}, 4'h1);
        checkOutput("midrst");
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_pulse", {3'b0, out_valid}, 4'h0);
        end

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)), 0, 2'b00, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
